// File: rtl/binary_encoder_83.sv
// Registered 8-to-3 encoder: one-hot index, highest-set-bit fallback with err on multi-hot.
// Latency 1 cycle; no backpressure, a new sample is accepted every clock.
module binary_encoder_83 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       En,
   input  logic [7:0] d,
   output logic [2:0] q,
   output logic       valid,
   output logic       err
);

   logic [7:0] d_minus_one;
   logic [7:0] low_cleared;
   logic       any_set;
   logic       one_hot;
   logic [2:0] top_idx;

   // Clearing the lowest set bit leaves zero only when at most one bit was set.
   assign d_minus_one = d - 8'd1;
   assign low_cleared = d & d_minus_one;
   assign any_set     = |d;
   assign one_hot     = any_set && (low_cleared == 8'd0);

   always_comb begin
      top_idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (d[i]) begin
            top_idx = i[2:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q     <= 3'd0;
         valid <= 1'b0;
         err   <= 1'b0;
      end else if (En) begin
         q     <= top_idx;
         valid <= any_set;
         err   <= any_set && !one_hot;
      end else begin
         q     <= 3'd0;
         valid <= 1'b0;
         err   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_binary_encoder_83.sv
// Directed and random stimulus for binary_encoder_83 against an arithmetic reference model.
module tb_binary_encoder_83;

   logic       clk;
   logic       rst_n;
   logic       En;
   logic [7:0] d;
   logic [2:0] q;
   logic       valid;
   logic       err;

   int tests_run = 0;
   int tests_failed = 0;

   binary_encoder_83 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .En    (En),
      .d     (d),
      .q     (q),
      .valid (valid),
      .err   (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: bit count decides valid/err, index is floor(log2(d)) by repeated halving.
   function automatic logic [4:0] model(input logic en_i, input logic [7:0] d_i);
      int n;
      int v;
      int idx;
      n = $countones(d_i);
      v = d_i;
      idx = 0;
      while (v > 1) begin
         v = v / 2;
         idx = idx + 1;
      end
      if (!en_i || n == 0) return 5'b000_0_0;
      return {idx[2:0], 1'b1, (n > 1)};
   endfunction

   task automatic check(input string tag, input logic [4:0] expv);
      logic [4:0] obs;
      obs = {q, valid, err};
      tests_run++;
      assert (obs === expv)
      else begin
         tests_failed++;
         $error("FAIL %s: observed q/valid/err=%b/%b/%b expected %b/%b/%b",
                tag, obs[4:2], obs[1], obs[0], expv[4:2], expv[1], expv[0]);
      end
   endtask

   // Apply inputs mid-cycle, then check just after the capturing edge.
   task automatic step(input string tag, input logic en_i, input logic [7:0] d_i);
      @(negedge clk);
      En = en_i;
      d  = d_i;
      @(posedge clk);
      #1;
      check(tag, model(en_i, d_i));
   endtask

   initial begin
      logic [7:0] sweep [9];
      logic [7:0] rd;
      logic       re;
      sweep = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

      rst_n = 1'b0;
      En    = 1'b1;
      d     = 8'h80;
      repeat (3) @(posedge clk);
      #1;
      check("reset_hold", 5'b000_0_0);

      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("reset_release_no_edge", 5'b000_0_0);

      for (int i = 0; i < 9; i++) begin
         step($sformatf("sweep_%02h", sweep[i]), 1'b1, sweep[i]);
      end

      step("en_low_10", 1'b0, 8'h10);
      check("en_low_const", 5'b000_0_0);
      step("en_high_10", 1'b1, 8'h10);
      check("en_high_const", 5'b100_1_0);

      step("multi_81", 1'b1, 8'h81);
      check("multi_81_const", 5'b111_1_1);
      step("multi_06", 1'b1, 8'h06);
      check("multi_06_const", 5'b010_1_1);
      step("multi_ff", 1'b1, 8'hFF);
      check("multi_ff_const", 5'b111_1_1);

      step("lat_01", 1'b1, 8'h01);
      @(negedge clk);
      d = 8'h40;
      #1;
      check("lat_between_edges", 5'b000_1_0);
      @(posedge clk);
      #1;
      check("lat_after_edge", 5'b110_1_0);

      step("midstream_q5", 1'b1, 8'h20);
      check("midstream_q5_const", 5'b101_1_0);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_drop", 5'b000_0_0);
      d = 8'h08;
      @(posedge clk);
      #1;
      check("reset_blocks_edge", 5'b000_0_0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("no_stale_after_release", 5'b000_0_0);
      step("post_reset_08", 1'b1, 8'h08);

      for (int v = 0; v < 256; v++) begin
         step($sformatf("exh_%02h", v), 1'b1, v[7:0]);
      end

      for (int k = 0; k < 200; k++) begin
         rd = 8'($urandom_range(0, 255));
         re = 1'($urandom_range(0, 3) != 0);
         step($sformatf("rand_%0d_en%0b_%02h", k, re, rd), re, rd);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
